// File: rtl/wide_add_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wide_add_sequencer: NWORDS x 32-bit add/sub, one word per cycle, LSW first |
// | through a single shared 32-bit Kogge-Stone adder. Revision 1.0            |
// +--------------------------------------------------------------------------+
module wide_add_sequencer #(
  parameter int NWORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [32*NWORDS-1:0]   in_a,
  input  logic [32*NWORDS-1:0]   in_b,
  input  logic                   in_sub,
  input  logic                   in_cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [32*NWORDS-1:0]   out_sum,
  output logic                   out_cout,
  output logic                   out_ovf,
  output logic                   busy
);

  localparam int                 CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0]   LAST   = CNT_W'(NWORDS - 1);
  localparam logic [1:0]         S_IDLE = 2'd0;
  localparam logic [1:0]         S_RUN  = 2'd1;
  localparam logic [1:0]         S_DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic                   carry_q;
  logic [32*NWORDS-1:0]   a_q, b_q, sum_q;
  logic                   cout_q, ovf_q;

  logic [31:0]            w_op_a, w_op_b, w_sum;
  logic                   w_cin, w_cout;
  logic [31:0]            w_g, w_p, w_gn, w_pn;
  logic [32:0]            w_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)      state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:  if (out_ready)     state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE:  in_ready  = 1'b1;
      S_RUN:   busy      = 1'b1;
      S_DONE:  begin out_valid = 1'b1; busy = 1'b1; end
      default: in_ready  = 1'b0;
    endcase
  end

  // Operands stay zero outside RUN so the adder never sees stale partial words
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    w_cin  = 1'b0;
    if (state_q == S_RUN) begin
      w_cin = carry_q;
      for (int i = 0; i < NWORDS; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          w_op_a = a_q[i*32 +: 32];
          w_op_b = b_q[i*32 +: 32];
        end
      end
    end
  end

  // 32-bit Kogge-Stone prefix adder: five radix-2 levels of (G,P) combining
  always_comb begin
    w_g = w_op_a & w_op_b;
    w_p = w_op_a ^ w_op_b;
    for (int lvl = 0; lvl < 5; lvl++) begin
      w_gn = w_g;
      w_pn = w_p;
      for (int i = (1 << lvl); i < 32; i++) begin
        w_gn[i] = w_g[i] | (w_p[i] & w_g[i - (1 << lvl)]);
        w_pn[i] = w_p[i] & w_p[i - (1 << lvl)];
      end
      w_g = w_gn;
      w_p = w_pn;
    end
    w_c[0] = w_cin;
    for (int i = 0; i < 32; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_cin);
    end
    w_sum  = w_op_a ^ w_op_b ^ w_c[31:0];
    w_cout = w_c[32];
  end

  // Subtraction is A + ~B + 1: B is inverted at capture and carry seeded with 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (in_valid) begin
        a_q     <= in_a;
        b_q     <= in_sub ? ~in_b : in_b;
        carry_q <= in_sub ? 1'b1 : in_cin;
        cnt_q   <= '0;
      end
    end else if (state_q == S_RUN) begin
      for (int i = 0; i < NWORDS; i++) begin
        if (cnt_q == CNT_W'(i)) sum_q[i*32 +: 32] <= w_sum;
      end
      carry_q <= w_cout;
      cnt_q   <= cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        cout_q <= w_cout;
        ovf_q  <= (w_op_a[31] == w_op_b[31]) & (w_sum[31] != w_op_a[31]);
      end
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wide_add_sequencer: directed self-checking bench, NWORDS=4. Rev 1.0     |
// +--------------------------------------------------------------------------+
module tb_wide_add_sequencer;

  localparam int NWORDS = 4;
  localparam int W      = 32 * NWORDS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_sub = 1'b0;
  logic          in_cin = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;

  wide_add_sequencer #(.NWORDS(NWORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bounded wait for out_valid; returns the number of clock edges consumed
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin, input logic [W-1:0] es,
                       input logic ec, input logic eo);
    int cyc;
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    check({tag, ".in_ready_idle"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, ".busy_run"}, busy, 1);
    check({tag, ".in_ready_run"}, in_ready, 0);
    wait_valid(cyc);
    check({tag, ".latency"}, cyc, NWORDS);
    check({tag, ".sum"}, out_sum, es);
    check({tag, ".cout"}, out_cout, ec);
    check({tag, ".ovf"}, out_ovf, eo);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, out_valid, 0);
    check({tag, ".in_ready_back"}, in_ready, 1);
    check({tag, ".sum_retained"}, out_sum, es);
  endtask

  localparam logic [W-1:0] BP1_A   = 128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0;
  localparam logic [W-1:0] BP1_B   = 128'h11111111_11111111_11111111_11111111;
  localparam logic [W-1:0] BP1_SUM = 128'h23456789_ABCDF001_20202021_02020201;
  localparam logic [W-1:0] BP2_A   = 128'h00000000_00000000_00000001_00000000;
  localparam logic [W-1:0] BP2_SUM = 128'h00000000_00000000_00000000_FFFFFFFF;

  initial begin
    int cyc;

    repeat (2) @(negedge clk);
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.sum", out_sum, 0);
    check("rst.cout", out_cout, 0);
    check("rst.ovf", out_ovf, 0);
    rst_n = 1'b1;

    do_op("add_wrap", {W{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1, 1'b0);
    do_op("sub_5_7", 128'd5, 128'd7, 1'b1, 1'b0, {{(W-2){1'b1}}, 2'b10}, 1'b0, 1'b0);
    do_op("sub_7_5", 128'd7, 128'd5, 1'b1, 1'b1, 128'd2, 1'b1, 1'b0);
    do_op("add_ovf", {1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0, 1'b0, {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1);
    do_op("xword_cin", 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd0, 1'b0, 1'b1,
          128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0);
    do_op("sub_ovf", {1'b1, {(W-1){1'b0}}}, 128'd1, 1'b1, 1'b0, {1'b0, {(W-1){1'b1}}}, 1'b1, 1'b1);

    // Backpressure: result held in DONE while a second bundle waits
    @(negedge clk);
    in_a = BP1_A; in_b = BP1_B; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(cyc);
    check("bp1.latency", cyc, NWORDS);
    in_a = BP2_A; in_b = 128'd1; in_sub = 1'b1; in_cin = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("bp.hold_valid", out_valid, 1);
      check("bp.hold_in_ready", in_ready, 0);
      check("bp.hold_sum", out_sum, BP1_SUM);
      @(negedge clk);
    end
    check("bp1.cout", out_cout, 0);
    check("bp1.ovf", out_ovf, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp.valid_drop", out_valid, 0);
    check("bp.in_ready_back", in_ready, 1);
    check("bp.sum_retained", out_sum, BP1_SUM);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp2.busy", busy, 1);
    wait_valid(cyc);
    check("bp2.latency", cyc, NWORDS);
    check("bp2.sum", out_sum, BP2_SUM);
    check("bp2.cout", out_cout, 1);
    check("bp2.ovf", out_ovf, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset asserted after two RUN cycles aborts the operation
    in_a = BP1_A; in_b = BP1_B; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst.busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst.sum", out_sum, 0);
    check("midrst.cout", out_cout, 0);
    check("midrst.ovf", out_ovf, 0);
    check("midrst.valid", out_valid, 0);
    check("midrst.busy", busy, 0);
    check("midrst.in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst_add", 128'd3, 128'd4, 1'b0, 1'b0, 128'd7, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
